// File: rtl/sec_timer_ctrl.sv
// Countdown timer controller: a one-second divider plus a BCD M:SS down-counter
// sequenced through IDLE/RUN/PAUSE/DONE. Every register updates on the falling clock edge.
module sec_timer_ctrl #(
  parameter int unsigned DIV = 24000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_min_u,
  input  logic [2:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] state,
  output logic       tick,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [24:0] CON_LAST = 25'(DIV - 32'd1);

  function automatic logic [3:0] sat_nine(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [2:0] sat_five(input logic [2:0] d);
    return (d > 3'd5) ? 3'd5 : d;
  endfunction

  state_t      state_r;
  logic [24:0] con_t_r;
  logic [3:0]  min_u_r;
  logic [2:0]  sec_t_r;
  logic [3:0]  sec_u_r;
  logic        tick_r;
  logic        done_r;

  logic        cmd_start_s;
  logic        cmd_stop_s;
  logic        load_ok_s;
  logic        wrap_s;
  logic        cnt_zero_s;
  logic        dec_zero_s;
  logic [24:0] con_inc_s;
  logic [3:0]  dec_min_u_s;
  logic [2:0]  dec_sec_t_s;
  logic [3:0]  dec_sec_u_s;

  // Command decode and the one-step BCD decrement of the current count
  always_comb begin
    cmd_start_s = start & ~stop;
    cmd_stop_s  = stop & ~start;
    load_ok_s   = load && (state_r != ST_RUN);
    wrap_s      = (con_t_r == CON_LAST);
    con_inc_s   = con_t_r + 25'd1;
    cnt_zero_s  = (min_u_r == 4'd0) && (sec_t_r == 3'd0) && (sec_u_r == 4'd0);
    dec_min_u_s = min_u_r;
    dec_sec_t_s = sec_t_r;
    dec_sec_u_s = sec_u_r;
    if (sec_u_r != 4'd0) begin
      dec_sec_u_s = sec_u_r - 4'd1;
    end else begin
      dec_sec_u_s = 4'd9;
      if (sec_t_r != 3'd0) begin
        dec_sec_t_s = sec_t_r - 3'd1;
      end else begin
        dec_sec_t_s = 3'd5;
        dec_min_u_s = min_u_r - 4'd1;
      end
    end
    dec_zero_s = (dec_min_u_s == 4'd0) && (dec_sec_t_s == 3'd0) && (dec_sec_u_s == 4'd0);
  end

  // Timer FSM with divider, count digits and registered tick/done
  always_ff @(negedge clk or negedge res) begin
    if (!res) begin
      state_r <= ST_IDLE;
      con_t_r <= 25'd0;
      min_u_r <= 4'd0;
      sec_t_r <= 3'd0;
      sec_u_r <= 4'd0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clear) begin
      state_r <= ST_IDLE;
      con_t_r <= 25'd0;
      min_u_r <= 4'd0;
      sec_t_r <= 3'd0;
      sec_u_r <= 4'd0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (load_ok_s) begin
      state_r <= ST_IDLE;
      con_t_r <= 25'd0;
      min_u_r <= sat_nine(ld_min_u);
      sec_t_r <= sat_five(ld_sec_t);
      sec_u_r <= sat_nine(ld_sec_u);
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tick_r  <= 1'b0;
          done_r  <= 1'b0;
          con_t_r <= 25'd0;
          if (cmd_start_s && !cnt_zero_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          done_r <= 1'b0;
          if (cmd_stop_s) begin
            // A stop on the wrap edge parks the divider at its last value so
            // the pending decrement fires on the first edge after resume.
            state_r <= ST_PAUSE;
            tick_r  <= 1'b0;
            con_t_r <= wrap_s ? con_t_r : con_inc_s;
          end else if (wrap_s && !cnt_zero_s) begin
            con_t_r <= 25'd0;
            tick_r  <= 1'b1;
            min_u_r <= dec_min_u_s;
            sec_t_r <= dec_sec_t_s;
            sec_u_r <= dec_sec_u_s;
            if (dec_zero_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else if (wrap_s) begin
            con_t_r <= 25'd0;
            tick_r  <= 1'b0;
          end else begin
            con_t_r <= con_inc_s;
            tick_r  <= 1'b0;
          end
        end
        ST_PAUSE: begin
          tick_r <= 1'b0;
          done_r <= 1'b0;
          if (cmd_start_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          tick_r  <= 1'b0;
          done_r  <= 1'b1;
          con_t_r <= 25'd0;
          min_u_r <= 4'd0;
          sec_t_r <= 3'd0;
          sec_u_r <= 4'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          con_t_r <= 25'd0;
          tick_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign min_u = min_u_r;
  assign sec_t = sec_t_r;
  assign sec_u = sec_u_r;
  assign state = state_r;
  assign tick  = tick_r;
  assign done  = done_r;

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Directed bench for sec_timer_ctrl with DIV=4: a vector table for the main flows
// plus hand sequences for pause/resume, stop on the wrap edge and async reset.
module tb_sec_timer_ctrl;

  localparam int unsigned DIV = 4;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_START = 4'b1000;
  localparam logic [3:0] C_STOP  = 4'b0100;
  localparam logic [3:0] C_CLEAR = 4'b0010;
  localparam logic [3:0] C_LOAD  = 4'b0001;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       res;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [3:0] ld_min_u;
  logic [2:0] ld_sec_t;
  logic [3:0] ld_sec_u;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] state;
  logic       tick;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] lm;
    logic [2:0] lt;
    logic [3:0] lu;
    logic [1:0] st;
    logic [3:0] m;
    logic [2:0] t;
    logic [3:0] u;
    logic       tk;
    logic       dn;
  } vec_t;

  vec_t vecs[$];
  int   s1_len;

  sec_timer_ctrl #(.DIV(DIV)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .ld_min_u (ld_min_u),
    .ld_sec_t (ld_sec_t),
    .ld_sec_u (ld_sec_u),
    .min_u    (min_u),
    .sec_t    (sec_t),
    .sec_u    (sec_u),
    .state    (state),
    .tick     (tick),
    .done     (done)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] cmd, input logic [3:0] lm, input logic [2:0] lt,
                              input logic [3:0] lu, input logic [1:0] st, input logic [3:0] m,
                              input logic [2:0] t, input logic [3:0] u, input logic tk, input logic dn);
    vec_t r;
    r.cmd = cmd; r.lm = lm; r.lt = lt; r.lu = lu;
    r.st = st; r.m = m; r.t = t; r.u = u; r.tk = tk; r.dn = dn;
    return r;
  endfunction

  task automatic drive_edge(input logic [3:0] cmd, input logic [3:0] lm, input logic [2:0] lt,
                            input logic [3:0] lu);
    {start, stop, clear, load} = cmd;
    ld_min_u = lm;
    ld_sec_t = lt;
    ld_sec_u = lu;
    @(negedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input int idx, input logic [1:0] st, input logic [3:0] m,
                           input logic [2:0] t, input logic [3:0] u, input logic tk, input logic dn);
    n_checks++;
    if ({state, min_u, sec_t, sec_u, tick, done} !== {st, m, t, u, tk, dn}) begin
      n_fail++;
      $display("FAIL %s[%0d]: got state=%0d %0d:%0d%0d tick=%0b done=%0b, expected state=%0d %0d:%0d%0d tick=%0b done=%0b",
               nm, idx, state, min_u, sec_t, sec_u, tick, done, st, m, t, u, tk, dn);
    end
  endtask

  task automatic apply(input vec_t v, input string nm, input int idx);
    drive_edge(v.cmd, v.lm, v.lt, v.lu);
    check_out(nm, idx, v.st, v.m, v.t, v.u, v.tk, v.dn);
  endtask

  initial begin
    int n;
    res = 1'b0;
    {start, stop, clear, load} = C_NONE;
    ld_min_u = 4'd0;
    ld_sec_t = 3'd0;
    ld_sec_u = 4'd0;

    // Scenario 1: load 0:03, start at edge 0, ticks at edges 4/8/12, then DONE with no ticks.
    vecs.push_back(mk(C_LOAD, 4'd0, 3'd0, 4'd3, S_IDLE, 4'd0, 3'd0, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd3, 1'b0, 1'b0));
    for (int e = 1; e <= 12; e++) begin
      vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, (e == 12) ? S_DONE : S_RUN, 4'd0, 3'd0,
                        4'(3 - e / 4), (e % 4 == 0) ? 1'b1 : 1'b0, (e == 12) ? 1'b1 : 1'b0));
    end
    for (int e = 0; e < 20; e++) begin
      vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_DONE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b1));
    end
    s1_len = vecs.size();

    // Scenarios 2 and 4: borrow chain, load/clear, priorities and ignored commands.
    vecs.push_back(mk(C_START, 4'd0, 3'd0, 4'd0, S_DONE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(C_LOAD, 4'd1, 3'd0, 4'd0, S_IDLE, 4'd1, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd1, 3'd0, 4'd0, 1'b0, 1'b0));
    for (int e = 0; e < 3; e++)
      vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd1, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd5, 4'd9, 1'b1, 1'b0));
    for (int e = 0; e < 3; e++)
      vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd5, 4'd9, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd5, 4'd8, 1'b1, 1'b0));
    vecs.push_back(mk(C_STOP, 4'd0, 3'd0, 4'd0, S_PAUSE, 4'd0, 3'd5, 4'd8, 1'b0, 1'b0));
    vecs.push_back(mk(C_LOAD, 4'd9, 3'd5, 4'd9, S_IDLE, 4'd9, 3'd5, 4'd9, 1'b0, 1'b0));
    vecs.push_back(mk(C_CLEAR, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_START, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_STOP, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_LOAD, 4'd0, 3'd1, 4'd0, S_IDLE, 4'd0, 3'd1, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd1, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_LOAD, 4'd5, 3'd5, 4'd5, S_RUN, 4'd0, 3'd1, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_START | C_STOP, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd1, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd1, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd9, 1'b1, 1'b0));
    vecs.push_back(mk(C_CLEAR | C_LOAD, 4'd5, 3'd5, 4'd5, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(C_LOAD, 4'd15, 3'd7, 4'd12, S_IDLE, 4'd9, 3'd5, 4'd9, 1'b0, 1'b0));

    #3;
    check_out("reset", 0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    #9;
    res = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], (i < s1_len) ? "scn1" : "scn2_4", i);

    // Scenario 3: pause two edges into a second, hold, resume; two RUN edges remain.
    apply(mk(C_CLEAR, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0), "pause", 0);
    apply(mk(C_LOAD, 4'd0, 3'd0, 4'd5, S_IDLE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "pause", 1);
    apply(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "pause", 2);
    apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "pause", 3);
    apply(mk(C_STOP, 4'd0, 3'd0, 4'd0, S_PAUSE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "pause", 4);
    for (int e = 0; e < 10; e++)
      apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_PAUSE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "pause_hold", e);
    apply(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "resume", 0);
    n = 0;
    while (n < 10) begin
      drive_edge(C_NONE, 4'd0, 3'd0, 4'd0);
      n++;
      if (tick === 1'b1) break;
    end
    n_checks++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL resume_latency: tick after %0d RUN edges, expected 2", n);
    end
    check_out("resume_tick", 0, S_RUN, 4'd0, 3'd0, 4'd4, 1'b1, 1'b0);

    // Scenario 5: stop on the wrap edge suppresses the decrement until resume.
    apply(mk(C_CLEAR, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0), "wrapstop", 0);
    apply(mk(C_LOAD, 4'd0, 3'd0, 4'd5, S_IDLE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop", 1);
    apply(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop", 2);
    for (int e = 0; e < 3; e++)
      apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop_run", e);
    apply(mk(C_STOP, 4'd0, 3'd0, 4'd0, S_PAUSE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop", 3);
    apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_PAUSE, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop", 4);
    apply(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd5, 1'b0, 1'b0), "wrapstop", 5);
    apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd4, 1'b1, 1'b0), "wrapstop", 6);

    // Scenario 6: asynchronous reset between edges, then a fresh scenario 1.
    apply(mk(C_CLEAR, 4'd0, 3'd0, 4'd0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0), "async", 0);
    apply(mk(C_LOAD, 4'd0, 3'd0, 4'd3, S_IDLE, 4'd0, 3'd0, 4'd3, 1'b0, 1'b0), "async", 1);
    apply(mk(C_START, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd3, 1'b0, 1'b0), "async", 2);
    apply(mk(C_NONE, 4'd0, 3'd0, 4'd0, S_RUN, 4'd0, 3'd0, 4'd3, 1'b0, 1'b0), "async", 3);
    #2;
    res = 1'b0;
    #1;
    check_out("async_rst", 0, S_IDLE, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    #2;
    res = 1'b1;
    for (int i = 0; i < s1_len; i++)
      apply(vecs[i], "after_rst", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sec_timer_ctrl.md
# sec_timer_ctrl

Countdown-timer controller for the seconds-counting datapath. It derives a one-second enable from the system clock with a divider and sequences a BCD minutes:seconds register (M:SS, 0:00–9:59) through idle, run, pause and done states under start/stop/clear/load commands. Its outputs drive the display and alarm logic directly.

## Interface
- `DIV`, default 24000: clock cycles per one-second tick. The default is 24 MHz scaled by 1/1000 for simulation; silicon uses 24000000. Legal range is 2 to 2^25.
- `clk`, input, 1: system clock. All registers update on the falling edge.
- `res`, input, 1: asynchronous active-low reset.
- `start`, input, 1: run request, sampled each edge (level; one edge is enough).
- `stop`, input, 1: pause request.
- `clear`, input, 1: abort and zero the count.
- `load`, input, 1: preset the count from `ld_min_u`/`ld_sec_t`/`ld_sec_u`.
- `ld_min_u`, input, 4: preset minutes digit.
- `ld_sec_t`, input, 3: preset tens-of-seconds digit.
- `ld_sec_u`, input, 4: preset units-of-seconds digit.
- `min_u`, output, 4: minutes digit, BCD.
- `sec_t`, output, 3: tens-of-seconds digit, 0–5.
- `sec_u`, output, 4: units-of-seconds digit, BCD.
- `state`, output, 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `tick`, output, 1: one-cycle pulse on every count decrement.
- `done`, output, 1: high while in DONE.

## Operation
- **Reset (`res`=0):** immediate. `state`=IDLE, all digits 0, `tick`=0, `done`=0, divider `con_t`=0.
- **Command priority per edge:** `clear` > `load` > `start`/`stop`.
  - If `start` and `stop` are both high with no clear/load, both are ignored that edge.
- **clear:** from any state, go to IDLE with digits = 0 and `con_t`=0.
- **load:**
  - Accepted in IDLE, PAUSE and DONE. Result is IDLE with digits = preset and `con_t`=0.
  - Ignored in RUN.
  - Out-of-range presets saturate: `ld_min_u`>9 gives 9, `ld_sec_t`>5 gives 5, `ld_sec_u`>9 gives 9.
- **start:**
  - IDLE with count ≠ 0:00 goes to RUN, `con_t`=0.
  - IDLE with count = 0:00 is ignored.
  - PAUSE goes to RUN; `con_t` is kept, so the partial second resumes.
  - Ignored in RUN and DONE.
- **stop:** RUN goes to PAUSE, freezing `con_t` and the digits. Ignored elsewhere.
- **Divider:**
  - Counts only in RUN, 0..DIV-1, then wraps to 0.
  - Holds in PAUSE. Is 0 in IDLE and DONE.
  - Width is 25 bits.
- **Decrement:** on the edge where RUN and `con_t`==DIV-1:
  - `sec_u` decrements, or becomes 9 with a borrow when it is 0.
  - On borrow, `sec_t` decrements, or becomes 5 with a borrow when it is 0.
  - On borrow, `min_u` decrements.
  - 0:00 is never decremented.
- **Expiry:** if a decrement produces 0:00, go to DONE on that same edge, `con_t`=0.
- **DONE:** digits hold 0:00 and `done`=1. Exit only via `clear` or `load`.
- **stop vs. wrap:** `stop` on the same edge as a decrement takes the stop; the decrement for that edge is suppressed and `con_t` holds at DIV-1. After resume, the decrement occurs on the first RUN edge.

## Timing
- All outputs are registered. No combinational path from the inputs to the outputs.
- **Tick:**
  - `tick`=1 for exactly the one cycle following a decrement edge. The new digit values appear on that same edge.
  - `tick`=0 in every non-RUN state, and 0 on the edge that enters PAUSE.
- **Start latency:**
  - Start accepted at edge E0 from IDLE gives `state`=RUN after E0.
  - First decrement at edge E0+DIV; subsequent decrements every DIV edges.
- **Done:** `done` and `state`=DONE assert on the same edge as the final decrement, which is also the last `tick`.
- **Resume:** total RUN edges between decrements equal DIV regardless of pause length.
- **Mid-operation reset:** an asynchronous `res` in any state forces the reset values within the same cycle. A command present at release is acted on at the first falling edge after `res` goes high.

## Test plan
(Bench uses DIV=4 and samples outputs after each falling edge.)
1. **Reset values:** assert reset, load 0:03, release, start at edge 0. Expected:
   - `state`=RUN.
   - `tick` at edges 4, 8, 12, with count 0:02, 0:01, 0:00.
   - `state`=DONE and `done`=1 from edge 12.
   - No further ticks in the following 20 edges.
2. **Borrow chain:** load 1:00 and start. Expected:
   - First tick gives 0:59; next gives 0:58.
   - Load 9:59 then clear gives 0:00 in IDLE.
3. **Pause/resume:** load 0:05, start at edge 0, stop at edge 2, hold 10 edges, start. Expected:
   - Digits frozen at 0:05 during the pause.
   - First tick arrives exactly 2 RUN edges after resume (4 RUN edges in total).
4. **Priority and ignores:**
   - start with count 0:00 in IDLE: stays IDLE.
   - load during RUN: ignored.
   - start+stop together in RUN: stays RUN.
   - clear+load together: gives 0:00.
   - load of 15/7/12: saturates to 9:59.
5. **Stop on the wrap edge:** assert stop on the edge where `con_t`==3. Expected:
   - `state`=PAUSE, no tick, digits unchanged.
   - After start, the decrement occurs on the next edge.
6. **Asynchronous reset mid-RUN:** drop `res` between edges. Expected:
   - Outputs 0 and IDLE immediately, with no clock edge needed.
   - After release, a fresh load/start sequence behaves as in scenario 1.
